// File: rtl/cpu_defs.sv
// Shared EXE-stage types: fixed-width words and the divider state encoding.
package cpu_defs;
  typedef logic [31:0] uint32_t;
  typedef logic [63:0] uint64_t;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;
endpackage

// File: rtl/iter_div.sv
// Radix-2 restoring divider with a 34-cycle turnaround. Magnitudes are divided,
// then the signs are re-applied to produce {quotient, remainder}.
module iter_div
  import cpu_defs::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        cancel,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);

  function automatic uint32_t neg_if(input uint32_t x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

  div_state_e r_state;
  logic [32:0] r_rem;
  uint32_t     r_quo;
  uint32_t     r_dvs;
  logic [4:0]  r_cnt;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_tvalid;
  uint64_t     r_tdata;

  logic        w_accept;
  logic        w_s1_neg;
  logic        w_s2_neg;
  logic [33:0] w_trial;
  logic        w_qbit;
  logic [32:0] w_rem_nxt;
  uint32_t     w_quo_nxt;

  // Both channels move together; reset also holds them off.
  assign w_accept = aresetn && (r_state == DIV_IDLE) && s_axis_dividend_tvalid &&
                    s_axis_divisor_tvalid && !cancel;
  assign s_axis_dividend_tready = w_accept;
  assign s_axis_divisor_tready  = w_accept;

  assign w_s1_neg = SIGNED & s_axis_dividend_tdata[31];
  assign w_s2_neg = SIGNED & s_axis_divisor_tdata[31];

  // The partial remainder stays below 2^32, so bit 33 of the trial is its sign.
  assign w_trial   = {r_rem, r_quo[31]} - {2'b00, r_dvs};
  assign w_qbit    = ~w_trial[33];
  assign w_rem_nxt = w_qbit ? w_trial[32:0] : {r_rem[31:0], r_quo[31]};
  assign w_quo_nxt = {r_quo[30:0], w_qbit};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= DIV_IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_tvalid <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= neg_if(s_axis_dividend_tdata, w_s1_neg);
            r_dvs   <= neg_if(s_axis_divisor_tdata, w_s2_neg);
            r_qneg  <= w_s1_neg ^ w_s2_neg;
            r_rneg  <= w_s1_neg;
            r_cnt   <= '0;
            r_state <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          if (cancel) begin
            r_state <= DIV_IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 5'd1;
            // Result is registered off the final iteration so the pulse lands in DONE.
            if (r_cnt == 5'd31) begin
              r_state  <= DIV_DONE;
              r_tvalid <= 1'b1;
              r_tdata  <= {neg_if(w_quo_nxt, r_qneg), neg_if(w_rem_nxt[31:0], r_rneg)};
            end
          end
        end
        DIV_DONE: r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  assign m_axis_dout_tvalid = r_tvalid;
  assign m_axis_dout_tdata  = r_tdata;

endmodule

// File: tb/tb_iter_div.sv
// Random and directed checks of unsigned and signed dividers against an
// arithmetic reference, including latency, handshake, cancel and reset.
module tb_iter_div;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        dvd_vld, dvs_vld, cancel;
  logic [31:0] dvd_dat, dvs_dat;
  logic        dvd_rdy_u, dvs_rdy_u, vld_u;
  logic        dvd_rdy_s, dvs_rdy_s, vld_s;
  logic [63:0] dat_u, dat_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] obs_u, obs_s;

  always #5 aclk = ~aclk;

  iter_div #(.SIGNED(1'b0)) u_div_u (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_dividend_tvalid(dvd_vld), .s_axis_dividend_tready(dvd_rdy_u),
    .s_axis_dividend_tdata(dvd_dat),
    .s_axis_divisor_tvalid(dvs_vld), .s_axis_divisor_tready(dvs_rdy_u),
    .s_axis_divisor_tdata(dvs_dat),
    .cancel(cancel), .m_axis_dout_tvalid(vld_u), .m_axis_dout_tdata(dat_u)
  );

  iter_div #(.SIGNED(1'b1)) u_div_s (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_dividend_tvalid(dvd_vld), .s_axis_dividend_tready(dvd_rdy_s),
    .s_axis_dividend_tdata(dvd_dat),
    .s_axis_divisor_tvalid(dvs_vld), .s_axis_divisor_tready(dvs_rdy_s),
    .s_axis_divisor_tdata(dvs_dat),
    .cancel(cancel), .m_axis_dout_tvalid(vld_s), .m_axis_dout_tdata(dat_s)
  );

  wire rdy_all = dvd_rdy_u & dvs_rdy_u & dvd_rdy_s & dvs_rdy_s;
  wire rdy_any = dvd_rdy_u | dvs_rdy_u | dvd_rdy_s | dvs_rdy_s;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating division on magnitudes; x/0 gives all-ones magnitude and remainder = dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, ma, mb, mq, mr;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (mb == 0) begin
      mq = 64'hFFFF_FFFF;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    if ((sa < 0) != (sb < 0)) mq = -mq;
    if (sa < 0) mr = -mr;
    return {mq[31:0], mr[31:0]};
  endfunction

  // Entered 1 time unit after a rising edge; returns 1 unit into T1 with valids still high.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    dvd_vld = 1'b1; dvs_vld = 1'b1; dvd_dat = a; dvs_dat = b; cancel = 1'b0;
    #1;
    chk("tready_T0", {63'b0, rdy_all}, 64'd1);
    @(posedge aclk); #1;
  endtask

  // Full operation: valids stay high with junk data until the result pulse.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    int lat_u, lat_s;
    bit rdy_bad;
    lat_u = 0; lat_s = 0; rdy_bad = 0;
    start_op(a, b);
    for (int c = 1; c <= 40 && lat_u == 0; c++) begin
      dvd_dat = $urandom; dvs_dat = $urandom;
      #1;
      if (rdy_any) rdy_bad = 1;
      if (vld_s && lat_s == 0) lat_s = c;
      if (vld_u) begin
        lat_u = c;
        obs_u = dat_u;
        obs_s = dat_s;
      end else begin
        @(posedge aclk); #1;
      end
    end
    dvd_vld = 1'b0; dvs_vld = 1'b0;
    chk("latency_u", 64'(lat_u), 64'd33);
    chk("latency_s", 64'(lat_s), 64'd33);
    chk("tready_busy", {63'b0, rdy_bad}, 64'd0);
    chk("data_u", obs_u, ref_div(a, b, 1'b0));
    chk("data_s", obs_s, ref_div(a, b, 1'b1));
    @(posedge aclk); #1;
    chk("pulse_end", {62'b0, vld_u, vld_s}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, keep_u;
    bit bad;
    aresetn = 1'b0; dvd_vld = 1'b1; dvs_vld = 1'b1; cancel = 1'b0;
    dvd_dat = 32'd100; dvs_dat = 32'd7;
    #12;
    chk("rst_tready", {63'b0, rdy_any}, 64'd0);
    chk("rst_tvalid", {62'b0, vld_u, vld_s}, 64'd0);
    chk("rst_tdata_u", dat_u, 64'd0);
    chk("rst_tdata_s", dat_s, 64'd0);
    dvd_vld = 1'b0; dvs_vld = 1'b0;
    @(posedge aclk); #1; aresetn = 1'b1;
    @(posedge aclk); #1;

    do_op(32'd100, 32'd7);
    chk("u_100_7", obs_u, 64'h0000000E_00000002);
    do_op(32'hFFFF_FFF9, 32'd2);
    chk("s_m7_2", obs_s, 64'hFFFFFFFD_FFFFFFFF);
    do_op(32'd7, 32'hFFFF_FFFE);
    chk("s_7_m2", obs_s, 64'hFFFFFFFD_00000001);
    do_op(32'h8000_0000, 32'hFFFF_FFFF);
    chk("s_min_m1", obs_s, 64'h80000000_00000000);
    do_op(32'd5, 32'd0);
    chk("u_div0", obs_u, 64'hFFFFFFFF_00000005);
    do_op(32'hFFFF_FFFF, 32'd1);
    chk("u_max_1", obs_u, 64'hFFFFFFFF_00000000);

    // Dividend alone must never start an operation.
    bad = 0;
    dvd_vld = 1'b1; dvs_vld = 1'b0; dvd_dat = 32'd50;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rdy_any || vld_u || vld_s) bad = 1;
      @(posedge aclk); #1;
    end
    chk("lone_valid", {63'b0, bad}, 64'd0);
    do_op(32'd50, 32'd5);

    // Cancel during T10: idle in T11, no pulse, old result held, new op unaffected.
    keep_u = obs_u[31:0];
    start_op(32'd1000, 32'd3);
    dvd_vld = 1'b0; dvs_vld = 1'b0;
    repeat (9) begin @(posedge aclk); #1; end
    cancel = 1'b1;
    @(posedge aclk); #1;
    cancel = 1'b0;
    chk("cancel_tvalid", {62'b0, vld_u, vld_s}, 64'd0);
    chk("cancel_keep", dat_u, obs_u);
    chk("cancel_keep_lo", {32'b0, dat_u[31:0]}, {32'b0, keep_u});
    dvd_vld = 1'b1; dvs_vld = 1'b1;
    #1;
    chk("cancel_idle_T11", {63'b0, rdy_all}, 64'd1);
    dvd_vld = 1'b0; dvs_vld = 1'b0;
    @(posedge aclk); #1;
    do_op(32'd9, 32'd3);
    chk("after_cancel", obs_u, 64'h00000003_00000000);

    // Asynchronous reset mid-calculation, away from any clock edge.
    start_op(32'd12345, 32'd17);
    dvd_vld = 1'b0; dvs_vld = 1'b0;
    repeat (14) begin @(posedge aclk); #1; end
    #2; aresetn = 1'b0; #1;
    dvd_vld = 1'b1; dvs_vld = 1'b1; #1;
    chk("arst_tdata_u", dat_u, 64'd0);
    chk("arst_tdata_s", dat_s, 64'd0);
    chk("arst_tvalid", {62'b0, vld_u, vld_s}, 64'd0);
    chk("arst_tready", {63'b0, rdy_any}, 64'd0);
    dvd_vld = 1'b0; dvs_vld = 1'b0;
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_op(32'd1, 32'd1);
    chk("after_reset", obs_u, 64'h00000001_00000000);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: b = $urandom_range(1, 300);
        default: ;
      endcase
      do_op(a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
